// File: rtl/skid_reg.sv
// skid_reg: two-entry valid/ready pipeline register with a one-word skid buffer.
// Sustains one word per cycle with in_ready, out_valid and out_data all registered.
// Optional feature macro: SKID_FLUSH_EN adds a flush input that squashes the contents.
module skid_reg #(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SKID_FLUSH_EN
    input  logic             flush,
`endif
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_fire;
    logic             out_fire;
    logic             flush_req;

    // Handshakes are qualified by the registered flags only, keeping outputs free of input paths.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

`ifdef SKID_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // State register and storage entries, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_q      <= INIT;
            skid_q      <= INIT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and entry update; flush squashes the state but leaves both entries untouched.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush_req) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Output flags decoded from the next state so they land in registers with the state.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_skid_reg.sv
// Self-checking bench for skid_reg: directed scenarios plus a random scoreboard run.
module tb_skid_reg;

    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] INIT_V = 32'hDEADBEEF;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_FLUSH_EN
    logic             flush;
`endif

    int checks;
    int failures;
    logic [WIDTH-1:0] sb[$];

    skid_reg #(.WIDTH(WIDTH), .INIT(INIT_V)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SKID_FLUSH_EN
        .flush     (flush),
`endif
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; inputs change and outputs are sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 32'h0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_data !== INIT_V) begin
            failures++;
            $display("FAIL reset_out_data got=%h exp=%h", out_data, INIT_V);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream;
        logic [WIDTH-1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 3);
            in_data  = 32'(i + 1);
            if (i > 0) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hX;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    failures++;
                    $display("FAIL stream_data cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp);
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, in_ready);
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_drain got_valid=%b left=%0d exp=0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        out_ready = 1'b0;
        in_data   = 32'hB;
        tick();
        in_data = 32'hBAD;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b data=%h exp 0/1/a", i, in_ready, out_valid, out_data);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_data !== 32'hA) begin
            failures++;
            $display("FAIL bp_first got=%h exp=a", out_data);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hB) begin
            failures++;
            $display("FAIL bp_second got rdy=%b vld=%b data=%h exp 1/1/b", in_ready, out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_empty got vld=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_full got rdy=%b exp=0", in_ready);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== INIT_V) begin
            failures++;
            $display("FAIL rmid_reset got vld=%b rdy=%b data=%h exp 0/1/%h", out_valid, in_ready, out_data, INIT_V);
        end
        reset     = 1'b1;
        sb.delete();
        in_valid  = 1'b1;
        in_data   = 32'hC;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hC) begin
            failures++;
            $display("FAIL rmid_c got vld=%b data=%h exp 1/c", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_stale got vld=%b data=%h exp vld=0", out_valid, out_data);
        end
    endtask

`ifdef SKID_FLUSH_EN
    task automatic test_flush;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        tick();
        in_data = 32'h6;
        tick();
        flush   = 1'b1;
        in_data = 32'h7;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got vld=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak cyc=%0d got vld=%b data=%h exp vld=0", i, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data  = 32'h8;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h8) begin
            failures++;
            $display("FAIL flush_after got vld=%b data=%h exp 1/8", out_valid, out_data);
        end
        tick();
    endtask
`endif

    task automatic test_random;
        logic [WIDTH-1:0] exp;
        logic             prev_hold;
        logic [WIDTH-1:0] prev_data;
        int               accepted;
        int               delivered;
        int               drain;
        sb.delete();
        prev_hold = 1'b0;
        prev_data = '0;
        accepted  = 0;
        delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_hold cyc=%0d got vld=%b data=%h exp 1/%h", c, out_valid, out_data, prev_data);
                end
            end
            checks++;
            if (out_valid !== (sb.size() > 0) || in_ready !== (sb.size() < 2)) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d got vld=%b rdy=%b occ=%0d", c, out_valid, in_ready, sb.size());
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom();
            if (out_valid && out_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hX;
                delivered++;
                checks++;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, exp);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                accepted++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (out_valid && drain < 8) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hX;
            delivered++;
            checks++;
            if (out_data !== exp) begin
                failures++;
                $display("FAIL rand_drain got=%h exp=%h", out_data, exp);
            end
            tick();
            drain++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || accepted != delivered) begin
            failures++;
            $display("FAIL rand_count acc=%0d del=%0d left=%0d vld=%b", accepted, delivered, sb.size(), out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data  = '0;
`ifdef SKID_FLUSH_EN
        flush    = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
`ifdef SKID_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
